// File: rtl/decode_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// decode_ctrl_pipe
//
// ID-stage instruction decoder with a registered ID/EX control word. It also
// produces the upstream stall: a load-use hazard against the instruction
// currently in EX, a downstream stall, or a multi-cycle MUL/DIV in flight.
//
// Parameters
//   ENABLE_UPPER   1: LUI/AUIPC decode normally; 0: they decode as illegal
//   ENABLE_MULDIV  1: R-type with funct7=0000001 decodes as MUL/DIV
//   MULDIV_LAT     number of BUSY cycles after a MUL/DIV issues (1..15)
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   in_valid, instr  ID-stage instruction
//   ex_stall         downstream stall, output register holds
//   flush_in         kill from EX, next output is a bubble
//   out_valid ..     registered ID/EX control bits, aluop, out_rd
//   stall_out        combinational, upstream holds PC and IF/ID while high
// ---------------------------------------------------------------------------
module decode_ctrl_pipe #(
    parameter bit          ENABLE_UPPER  = 1'b1,
    parameter bit          ENABLE_MULDIV = 1'b0,
    parameter int unsigned MULDIV_LAT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic        ex_stall,
    input  logic        flush_in,
    output logic        out_valid,
    output logic        jalr,
    output logic        jal,
    output logic        branch,
    output logic        memread,
    output logic        memtoreg,
    output logic        memwrite,
    output logic        alusrc,
    output logic        regwrite,
    output logic        flush,
    output logic        lui,
    output logic        auipc,
    output logic        muldiv,
    output logic        illegal,
    output logic [1:0]  aluop,
    output logic [4:0]  out_rd,
    output logic        stall_out
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_MD    = 7'b0000001;

    localparam logic [3:0] CNT_INIT = 4'(MULDIV_LAT - 1);

    typedef struct packed {
        logic       valid;
        logic       jalr;
        logic       jal;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic       flush;
        logic       lui;
        logic       auipc;
        logic       muldiv;
        logic       illegal;
        logic [1:0] aluop;
        logic [4:0] rd;
    } ctrl_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    ctrl_t      ctrl_d, ctrl_q, dec;
    state_t     state_d, state_q;
    logic [3:0] cnt_d, cnt_q;
    logic       rs1_used, rs2_used;
    logic       load_use;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2;
    logic       unused_funct3;

    assign opcode        = instr[6:0];
    assign funct7        = instr[31:25];
    assign rs1           = instr[19:15];
    assign rs2           = instr[24:20];
    assign unused_funct3 = ^instr[14:12];

    // Combinational decode of the ID-stage instruction.
    always_comb begin
        dec      = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        unique case (opcode)
            OP_R: begin
                if (funct7 == F7_MD) begin
                    if (ENABLE_MULDIV) begin
                        dec.muldiv   = 1'b1;
                        dec.regwrite = 1'b1;
                        rs1_used     = 1'b1;
                        rs2_used     = 1'b1;
                    end else begin
                        dec.illegal  = 1'b1;
                    end
                end else begin
                    dec.regwrite = 1'b1;
                    rs1_used     = 1'b1;
                    rs2_used     = 1'b1;
                end
            end
            OP_I: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = 2'b01;
                rs1_used     = 1'b1;
            end
            OP_LOAD: begin
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = 2'b10;
                rs1_used     = 1'b1;
            end
            OP_STORE: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = 2'b10;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
            end
            OP_B: begin
                dec.branch   = 1'b1;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
            end
            OP_JAL: begin
                dec.jal      = 1'b1;
                dec.regwrite = 1'b1;
                dec.flush    = 1'b1;
                dec.aluop    = 2'b11;
            end
            OP_JALR: begin
                dec.jalr     = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.flush    = 1'b1;
                dec.aluop    = 2'b11;
                rs1_used     = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                if (ENABLE_UPPER) begin
                    dec.lui      = (opcode == OP_LUI);
                    dec.auipc    = (opcode == OP_AUIPC);
                    dec.alusrc   = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.aluop    = 2'b01;
                end else begin
                    dec.illegal  = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.valid = 1'b1;
        dec.rd    = dec.regwrite ? instr[11:7] : 5'd0;
    end

    // Hazard against the load currently sitting in the ID/EX register.
    // out_rd is already 0 for non-writing instructions, so x0 never matches.
    assign load_use = ctrl_q.valid & ctrl_q.memread & (ctrl_q.rd != 5'd0) & in_valid &
                      ((rs1_used & (rs1 == ctrl_q.rd)) | (rs2_used & (rs2 == ctrl_q.rd)));

    assign stall_out = ex_stall | load_use | (state_q == BUSY);

    // Output register / FSM next state, in priority order.
    always_comb begin
        ctrl_d  = ctrl_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_in) begin
            ctrl_d  = '0;
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (ex_stall) begin
            ctrl_d  = ctrl_q;
        end else if (state_q == BUSY) begin
            ctrl_d = '0;
            if (cnt_q == 4'd0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (load_use) begin
            ctrl_d = '0;
        end else if (in_valid) begin
            ctrl_d = dec;
            if (dec.muldiv) begin
                state_d = BUSY;
                cnt_d   = CNT_INIT;
            end
        end else begin
            ctrl_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = ctrl_q.valid;
    assign jalr      = ctrl_q.jalr;
    assign jal       = ctrl_q.jal;
    assign branch    = ctrl_q.branch;
    assign memread   = ctrl_q.memread;
    assign memtoreg  = ctrl_q.memtoreg;
    assign memwrite  = ctrl_q.memwrite;
    assign alusrc    = ctrl_q.alusrc;
    assign regwrite  = ctrl_q.regwrite;
    assign flush     = ctrl_q.flush;
    assign lui       = ctrl_q.lui;
    assign auipc     = ctrl_q.auipc;
    assign muldiv    = ctrl_q.muldiv;
    assign illegal   = ctrl_q.illegal;
    assign aluop     = ctrl_q.aluop;
    assign out_rd    = ctrl_q.rd;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_decode_ctrl_pipe
//
// Two decoder instances share one stimulus stream:
//   instance 0: ENABLE_UPPER=1, ENABLE_MULDIV=1, MULDIV_LAT=4
//   instance 1: ENABLE_UPPER=0, ENABLE_MULDIV=0, MULDIV_LAT=2
// A reference model predicts each cycle's stall_out and the next output
// word; monitors compare them against the DUTs.
// Output word layout (21 bits, MSB first):
//   out_valid jalr jal branch memread memtoreg memwrite alusrc regwrite
//   flush lui auipc muldiv illegal aluop[1:0] out_rd[4:0]
// ---------------------------------------------------------------------------
module tb_decode_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        ex_stall = 1'b0;
    logic        flush_in = 1'b0;

    logic       ov[2], o_jalr[2], o_jal[2], o_br[2], o_mr[2], o_mtr[2], o_mw[2];
    logic       o_as[2], o_rw[2], o_fl[2], o_lui[2], o_auipc[2], o_md[2], o_ill[2];
    logic [1:0] o_aluop[2];
    logic [4:0] o_rd[2];
    logic       o_stall[2];

    int n_vec  = 0;
    int n_miss = 0;

    bit eu[2]  = '{1'b1, 1'b0};
    bit em[2]  = '{1'b1, 1'b0};
    int lat[2] = '{4, 2};

    logic [20:0] m_out[2];
    int          m_busy[2];
    logic [41:0] out_q[$];
    logic [1:0]  st_q[$];

    always #5 clk = ~clk;

    decode_ctrl_pipe #(.ENABLE_UPPER(1'b1), .ENABLE_MULDIV(1'b1), .MULDIV_LAT(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
        .ex_stall(ex_stall), .flush_in(flush_in),
        .out_valid(ov[0]), .jalr(o_jalr[0]), .jal(o_jal[0]), .branch(o_br[0]),
        .memread(o_mr[0]), .memtoreg(o_mtr[0]), .memwrite(o_mw[0]), .alusrc(o_as[0]),
        .regwrite(o_rw[0]), .flush(o_fl[0]), .lui(o_lui[0]), .auipc(o_auipc[0]),
        .muldiv(o_md[0]), .illegal(o_ill[0]), .aluop(o_aluop[0]), .out_rd(o_rd[0]),
        .stall_out(o_stall[0]));

    decode_ctrl_pipe #(.ENABLE_UPPER(1'b0), .ENABLE_MULDIV(1'b0), .MULDIV_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
        .ex_stall(ex_stall), .flush_in(flush_in),
        .out_valid(ov[1]), .jalr(o_jalr[1]), .jal(o_jal[1]), .branch(o_br[1]),
        .memread(o_mr[1]), .memtoreg(o_mtr[1]), .memwrite(o_mw[1]), .alusrc(o_as[1]),
        .regwrite(o_rw[1]), .flush(o_fl[1]), .lui(o_lui[1]), .auipc(o_auipc[1]),
        .muldiv(o_md[1]), .illegal(o_ill[1]), .aluop(o_aluop[1]), .out_rd(o_rd[1]),
        .stall_out(o_stall[1]));

    function automatic logic [20:0] obs(int k);
        return {ov[k], o_jalr[k], o_jal[k], o_br[k], o_mr[k], o_mtr[k], o_mw[k],
                o_as[k], o_rw[k], o_fl[k], o_lui[k], o_auipc[k], o_md[k], o_ill[k],
                o_aluop[k], o_rd[k]};
    endfunction

    // Reference decode: classify, then build the control word from the table.
    // Returns {rs1_used, rs2_used, word[20:0]}.
    function automatic logic [22:0] ref_decode(logic [31:0] ins, bit up, bit md);
        string      cls;
        logic [6:0] op;
        logic       jr, jl, br, mr, mtr, mw, as, rw, fl, lu, au, mu, il, u1, u2;
        logic [1:0] alu;
        logic [4:0] rd;
        op = ins[6:0];
        case (op)
            7'b0110011: cls = (ins[31:25] == 7'b0000001) ? (md ? "MD" : "ILL") : "R";
            7'b0010011: cls = "I";
            7'b0000011: cls = "LD";
            7'b0100011: cls = "ST";
            7'b1100011: cls = "B";
            7'b1101111: cls = "JAL";
            7'b1100111: cls = "JALR";
            7'b0110111: cls = up ? "LUI" : "ILL";
            7'b0010111: cls = up ? "AUIPC" : "ILL";
            default:    cls = "ILL";
        endcase
        jr  = (cls == "JALR");
        jl  = (cls == "JAL");
        br  = (cls == "B");
        mr  = (cls == "LD");
        mtr = (cls == "LD");
        mw  = (cls == "ST");
        as  = (cls == "I") || (cls == "LD") || (cls == "ST") || (cls == "JALR") ||
              (cls == "LUI") || (cls == "AUIPC");
        rw  = (cls == "R") || (cls == "I") || (cls == "LD") || (cls == "JAL") ||
              (cls == "JALR") || (cls == "LUI") || (cls == "AUIPC") || (cls == "MD");
        fl  = (cls == "JAL") || (cls == "JALR");
        lu  = (cls == "LUI");
        au  = (cls == "AUIPC");
        mu  = (cls == "MD");
        il  = (cls == "ILL");
        if ((cls == "I") || (cls == "LUI") || (cls == "AUIPC")) alu = 2'b01;
        else if ((cls == "LD") || (cls == "ST"))                 alu = 2'b10;
        else if ((cls == "JAL") || (cls == "JALR"))              alu = 2'b11;
        else                                                     alu = 2'b00;
        u1 = (cls == "R") || (cls == "I") || (cls == "LD") || (cls == "ST") ||
             (cls == "B") || (cls == "JALR") || (cls == "MD");
        u2 = (cls == "R") || (cls == "ST") || (cls == "B") || (cls == "MD");
        rd = rw ? ins[11:7] : 5'd0;
        return {u1, u2, 1'b1, jr, jl, br, mr, mtr, mw, as, rw, fl, lu, au, mu, il, alu, rd};
    endfunction

    // One stimulus cycle: drive at the falling edge, predict, push expectations.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic st,
                         input logic fl);
        logic [41:0] onext;
        logic [1:0]  snow;
        @(negedge clk);
        in_valid = iv;
        instr    = ins;
        ex_stall = st;
        flush_in = fl;
        for (int k = 0; k < 2; k++) begin
            logic [22:0] d;
            logic        hz, stl;
            logic [4:0]  prd;
            d   = ref_decode(ins, eu[k], em[k]);
            prd = m_out[k][4:0];
            hz  = m_out[k][20] & m_out[k][16] & (prd != 5'd0) & iv &
                  ((d[22] & (ins[19:15] == prd)) | (d[21] & (ins[24:20] == prd)));
            stl = st | hz | (m_busy[k] > 0);
            snow[k] = stl;
            if (fl) begin
                m_out[k]  = '0;
                m_busy[k] = 0;
            end else if (st) begin
                // hold
            end else if (m_busy[k] > 0) begin
                m_out[k]  = '0;
                m_busy[k] = m_busy[k] - 1;
            end else if (hz || !iv) begin
                m_out[k]  = '0;
            end else begin
                m_out[k] = d[20:0];
                if (d[8]) m_busy[k] = lat[k];
            end
        end
        onext = {m_out[1], m_out[0]};
        out_q.push_back(onext);
        st_q.push_back(snow);
    endtask

    task automatic check_zero_and_stall(input string tag);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (obs(k) !== 21'd0) begin
                n_miss++;
                $display("FAIL %s dut%0d outputs got=%h exp=%h", tag, k, obs(k), 21'd0);
            end
            n_vec++;
            if (o_stall[k] !== ex_stall) begin
                n_miss++;
                $display("FAIL %s dut%0d stall_out got=%b exp=%b", tag, k, o_stall[k], ex_stall);
            end
        end
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic reset_pulse();
        @(negedge clk);
        in_valid = 1'b0;
        ex_stall = 1'b0;
        flush_in = 1'b0;
        #1 rst = 1'b1;
        #1 check_zero_and_stall("async_reset");
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_out[k]  = '0;
            m_busy[k] = 0;
        end
        #1 check_zero_and_stall("post_reset");
    endtask

    // Output monitor: compare the registered word just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (out_q.size() > 0) begin
                logic [41:0] e;
                e = out_q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    n_vec++;
                    if (obs(k) !== e[k*21 +: 21]) begin
                        n_miss++;
                        $display("FAIL outputs dut%0d t=%0t instr=%h got=%h exp=%h",
                                 k, $time, instr, obs(k), e[k*21 +: 21]);
                    end
                end
            end
        end
    end

    // Stall monitor: compare the combinational stall inside the low phase.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (st_q.size() > 0) begin
                logic [1:0] s;
                s = st_q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    n_vec++;
                    if (o_stall[k] !== s[k]) begin
                        n_miss++;
                        $display("FAIL stall_out dut%0d t=%0t instr=%h got=%b exp=%b",
                                 k, $time, instr, o_stall[k], s[k]);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[10];
        logic [6:0] op, f7;
        logic [4:0] rd, r1, r2;
        int         sel;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        sel = $urandom_range(0, 9);
        op  = (sel == 9) ? 7'($urandom) : ops[sel];
        case ($urandom_range(0, 2))
            0:       f7 = 7'b0000000;
            1:       f7 = 7'b0000001;
            default: f7 = 7'b0100000;
        endcase
        rd = 5'($urandom_range(0, 3));
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        return {f7, r2, r1, 3'($urandom), rd, op};
    endfunction

    localparam logic [31:0] I_ADDI = 32'h00A28293;  // addi x5,x5,10
    localparam logic [31:0] I_LW   = 32'h0002A303;  // lw   x6,0(x5)
    localparam logic [31:0] I_ADD  = 32'h001303B3;  // add  x7,x6,x1
    localparam logic [31:0] I_MUL  = 32'h02A48433;  // mul  x8,x9,x10
    localparam logic [31:0] I_LUI  = 32'h000122B7;  // lui  x5,0x12
    localparam logic [31:0] I_JAL  = 32'h008000EF;  // jal  x1,8

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_out[k]  = '0;
            m_busy[k] = 0;
        end
        #2 check_zero_and_stall("reset_state");
        ex_stall = 1'b1;
        #1 check_zero_and_stall("reset_exstall");
        ex_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // basic decode, then load-use
        cycle(1, I_ADDI, 0, 0);
        cycle(1, I_LW,   0, 0);
        cycle(1, I_ADD,  0, 0);
        cycle(1, I_ADD,  0, 0);
        cycle(0, 32'd0,  0, 0);
        // MUL/DIV with an ex_stall pulse inside BUSY
        cycle(1, I_MUL,  0, 0);
        cycle(1, I_ADDI, 0, 0);
        cycle(1, I_ADDI, 1, 0);
        cycle(1, I_ADDI, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, I_ADDI, 0, 0);
        // upper immediate on both configurations
        cycle(1, I_LUI,  0, 0);
        // flush coincident with jal; then a 3-cycle hold
        cycle(1, I_JAL,  0, 1);
        cycle(1, I_ADDI, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, I_LW, 1, 0);
        // flush together with a load-use hazard
        cycle(1, I_LW,   0, 0);
        cycle(1, I_ADD,  0, 1);
        cycle(1, I_ADD,  0, 0);
        // reset in the middle of BUSY
        cycle(1, I_MUL,  0, 0);
        cycle(0, 32'd0,  0, 0);
        reset_pulse();
        cycle(1, I_ADDI, 0, 0);
        cycle(0, 32'd0,  0, 0);

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, rand_instr(),
                  ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 6)  ? 1'b1 : 1'b0);
        end
        cycle(0, 32'd0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        n_vec++;
        if (out_q.size() != 0 || st_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain pending got=%0d exp=0", out_q.size() + st_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
